// File: rtl/expr_gen_if.sv
// Request/stream bundle for expr_gen.
// master: the side that issues expression requests and consumes bytes.
// slave:  the generator itself.
interface expr_gen_if #(
    parameter int MAX_TERMS = 8
);
    logic                     start;
    logic [3:0]               n_terms;
    logic [4*MAX_TERMS-1:0]   digits;
    logic [MAX_TERMS-2:0]     ops;
    logic                     ready;
    logic [7:0]               out;
    logic                     valid;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, n_terms, digits, ops, ready,
        input  out, valid, busy, done, err
    );

    modport slave (
        input  start, n_terms, digits, ops, ready,
        output out, valid, busy, done, err
    );
endinterface

// File: rtl/expr_gen.sv
// expr_gen: emits an ASCII arithmetic expression such as "7+2*5" one byte
// at a time over a valid/ready stream, built from latched BCD operands and
// an operator mask.
//
// Optional build macro EXPR_GEN_TERM_EN: appends a terminating '=' after the
// last digit (extra TERM state).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; validates request, pulses err on reject
// DIGIT | offering '0'+term[index]
// OP    | offering '*' or '+' that follows term[index]
// TERM  | offering '=' (only with EXPR_GEN_TERM_EN)
// FIN   | one-cycle done pulse, no byte offered
module expr_gen #(
    parameter int MAX_TERMS = 8
) (
    input  logic      clk,
    input  logic      clr,
    expr_gen_if.slave bus
);

    localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIGIT = 3'd1,
        OP    = 3'd2,
`ifdef EXPR_GEN_TERM_EN
        TERM  = 3'd3,
`endif
        FIN   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_nx;
    logic [3:0]             idx_q;
    logic [3:0]             idx_nx;
    logic [3:0]             n_q;
    logic [4*MAX_TERMS-1:0] digits_q;
    logic [MAX_TERMS-2:0]   ops_q;
    logic                   err_q;
    logic                   err_nx;
    logic                   accept;

    logic                   digit_bad;
    logic                   req_ok;
    logic [63:0]            dig_ext;
    logic [15:0]            ops_ext;
    logic [3:0]             cur_digit;
    logic                   cur_mul;

    logic [7:0]             out_c;
    logic                   valid_c;
    logic                   busy_c;
    logic                   done_c;

    // Zero-extended copies so a 4-bit index can address any term/operator
    // regardless of MAX_TERMS.
    assign dig_ext   = 64'(digits_q);
    assign ops_ext   = 16'(ops_q);
    assign cur_digit = dig_ext[{idx_q, 2'b00} +: 4];
    assign cur_mul   = ops_ext[idx_q];

    // Request check: only nibbles of the terms actually used must be BCD.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((i < int'(bus.n_terms)) && (bus.digits[4*i +: 4] > 4'd9)) begin
                digit_bad = 1'b1;
            end
        end
    end

    assign req_ok = (bus.n_terms != 4'd0) && (bus.n_terms <= MAX_N) && !digit_bad;

    // State, index, error pulse and request latches.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            err_q    <= 1'b0;
            n_q      <= 4'd0;
            digits_q <= '0;
            ops_q    <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            err_q   <= err_nx;
            if (accept) begin
                n_q      <= bus.n_terms;
                digits_q <= bus.digits;
                ops_q    <= bus.ops;
            end
        end
    end

    // Next-state and stream outputs; out stays 0 whenever nothing is offered.
    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        err_nx   = 1'b0;
        accept   = 1'b0;
        out_c    = 8'd0;
        valid_c  = 1'b0;
        busy_c   = 1'b1;
        done_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    if (req_ok) begin
                        accept   = 1'b1;
                        idx_nx   = 4'd0;
                        state_nx = DIGIT;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            DIGIT: begin
                valid_c = 1'b1;
                out_c   = 8'd48 + {4'd0, cur_digit};
                if (bus.ready) begin
                    if (idx_q < n_q - 4'd1) begin
                        state_nx = OP;
                    end else begin
`ifdef EXPR_GEN_TERM_EN
                        state_nx = TERM;
`else
                        state_nx = FIN;
`endif
                    end
                end
            end
            OP: begin
                valid_c = 1'b1;
                out_c   = cur_mul ? 8'd42 : 8'd43;
                if (bus.ready) begin
                    idx_nx   = idx_q + 4'd1;
                    state_nx = DIGIT;
                end
            end
`ifdef EXPR_GEN_TERM_EN
            TERM: begin
                valid_c = 1'b1;
                out_c   = 8'd61;
                if (bus.ready) begin
                    state_nx = FIN;
                end
            end
`endif
            FIN: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.out   = out_c;
    assign bus.valid = valid_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.err   = err_q;

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 8, giving the maximum operand count per expression (legal range 2..15).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to emit one expression; sampled only in IDLE.
REQ-005 n_terms  input  4  operand count for the request; legal range 1..MAX_TERMS.
REQ-006 digits  input  4*MAX_TERMS  BCD operands; term i is digits[4i+3:4i], and term 0 is emitted first.
REQ-007 ops  input  MAX_TERMS-1  operator after term i; bit i=1 selects '*' (42), 0 selects '+' (43).
REQ-008 ready  input  1  downstream consumer can accept a byte this cycle.
REQ-009 out  output  8  ASCII byte being offered.
REQ-010 valid  output  1  out holds a byte to transfer.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when an expression completes.
REQ-013 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 A byte SHALL transfer on a rising edge where valid and ready are both 1.
REQ-015 While valid=1 and ready=0, out and valid SHALL hold their values.
REQ-016 States: IDLE, DIGIT, OP, (TERM when configured), FIN.
REQ-017 In IDLE with start=1, legal n_terms, and every used digit nibble (terms 0..n_terms-1) <=9, the block SHALL latch digits, ops and n_terms, clear the term index, and enter DIGIT.
REQ-018 Changes to the digits, ops and n_terms inputs after they are latched SHALL have no effect on the expression in progress.
REQ-019 In IDLE, start=1 with n_terms=0, n_terms>MAX_TERMS, or any used nibble >9 SHALL pulse err on the next cycle and SHALL stay in IDLE with no byte offered.
REQ-020 Unused nibbles and unused ops bits SHALL be ignored.
REQ-021 DIGIT SHALL offer 48+term[index]; on transfer it SHALL go to OP if index<n_terms-1, otherwise to TERM or FIN.
REQ-022 OP SHALL offer 42 or 43 per ops[index]; on transfer it SHALL increment index and go to DIGIT.
REQ-023 Latency: valid SHALL first be 1 in the cycle after start is accepted.
REQ-024 With ready held at 1, consecutive bytes SHALL be offered on consecutive cycles with no bubbles.
REQ-025 FIN SHALL drive valid=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 The emitted stream SHALL always match digit((+|*)digit)*, so the downstream expression recognizer accepts it.
REQ-028 When valid=0, out SHALL be 0.

Reset
REQ-029 clr=1 at a rising edge SHALL force IDLE, index=0, out=0, valid=0, busy=0, done=0 and err=0, overriding all other inputs.
REQ-030 A reset mid-expression SHALL abandon the expression with no done pulse, and the next accepted start SHALL begin a new expression from term 0.

Configuration
REQ-031 Macro EXPR_GEN_TERM_EN: when defined, the TERM state SHALL follow the last digit, offering '=' (61) under the same handshake before FIN.
REQ-032 When EXPR_GEN_TERM_EN is undefined, the TERM state SHALL not exist and the last digit's transfer SHALL go directly to FIN.

Verification
REQ-033 n_terms=3, digits=...0_5_2_7, ops=...10, ready=1 -> bytes 55,43,50,42,53 ('7+2*5') on 5 consecutive cycles, then done=1 for one cycle.
REQ-034 n_terms=1, digit 9, ready=1 -> single byte 57, then done; with EXPR_GEN_TERM_EN, bytes 57,61, then done.
REQ-035 Same stimulus as REQ-033 with ready=0 for 3 cycles while the second byte is offered -> out holds 43 and valid holds 1 through the stall, and the stream is unchanged.
REQ-036 start with n_terms=0, then start with term 1 nibble=12 (n_terms=2) -> err pulse each time, valid never 1, state remains IDLE.
REQ-037 clr asserted after 2 bytes of a 5-term expression -> all outputs 0 next cycle with no done pulse; a new start emits from term 0.
REQ-038 start pulsed while busy, and digits changed mid-stream -> no effect on the current stream.
